// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// the reset encoding, and the counter next-state function.
// No ports; imported by branch_predict_ctrl.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_cnt_e;

    localparam bp_cnt_e BP_RST = BP_WNT;

    // Saturating step of a 2-bit counter towards the resolved outcome.
    function automatic bp_cnt_e bp_cnt_next(input bp_cnt_e cur, input logic taken);
        bp_cnt_e nxt;
        nxt = cur;
        case (cur)
            BP_SNT:  nxt = taken ? BP_WNT : BP_SNT;
            BP_WNT:  nxt = taken ? BP_WT  : BP_SNT;
            BP_WT:   nxt = taken ? BP_ST  : BP_WNT;
            BP_ST:   nxt = taken ? BP_ST  : BP_WT;
            default: nxt = BP_RST;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-low reset (clears to 0)
//   en_i   - count this cycle
//   cnt_o  - current count
module bp_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            cnt_o <= '0;
        else if (en_i && (cnt_o != '1))
            cnt_o <= cnt_o + 1'b1;
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor: table of 2-bit saturating counters indexed by
// PC (optionally XORed with global history, gshare), trained from EX.
// Ports:
//   clk_i, rst_i           - clock, synchronous active-low reset
//   static_i               - force not-taken prediction (table still trains)
//   lkp_pc_i               - PC in ID
//   predict_o, lkp_idx_o   - combinational prediction and table index
//   upd_valid_i/idx/taken/pred - resolved branch from EX
//   br_cnt_o, miss_cnt_o   - branch / mispredict statistics (saturating)
//   ghr_o                  - global history (0 when HIST_W=0)
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int HIST_W = 0,
    parameter int STAT_W = 32,
    localparam int GW    = (HIST_W > 0) ? HIST_W : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              static_i,
    input  logic [31:0]       lkp_pc_i,
    output logic              predict_o,
    output logic [IDX_W-1:0]  lkp_idx_o,
    input  logic              upd_valid_i,
    input  logic [IDX_W-1:0]  upd_idx_i,
    input  logic              upd_taken_i,
    input  logic              upd_pred_i,
    output logic [STAT_W-1:0] br_cnt_o,
    output logic [STAT_W-1:0] miss_cnt_o,
    output logic [GW-1:0]     ghr_o
);

    localparam int ENTRIES = 2 ** IDX_W;

    // Register array so reset can restore every entry in one cycle.
    bp_cnt_e          tbl [ENTRIES];
    logic [GW-1:0]    ghr;
    logic [1:0]       lkp_cnt;

    // Instruction-aligned PC bits select the entry; low bits and high bits unused.
    logic unused_pc;
    assign unused_pc = ^{lkp_pc_i[31:IDX_W+2], lkp_pc_i[1:0]};

    // ghr is constant 0 for plain PC indexing, so the XOR is a no-op there.
    assign lkp_idx_o = lkp_pc_i[IDX_W+1:2] ^ IDX_W'(ghr);
    assign lkp_cnt   = tbl[lkp_idx_o];
    // Read is pre-update: no bypass from a same-cycle write.
    assign predict_o = ~static_i & lkp_cnt[1];
    assign ghr_o     = ghr;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= BP_RST;
        end else if (upd_valid_i) begin
            tbl[upd_idx_i] <= bp_cnt_next(tbl[upd_idx_i], upd_taken_i);
        end
    end

    // History shifts only on resolution (non-speculative).
    generate
        if (HIST_W == 0) begin : g_no_hist
            assign ghr = '0;
        end else if (HIST_W == 1) begin : g_hist1
            always_ff @(posedge clk_i) begin
                if (!rst_i)
                    ghr <= '0;
                else if (upd_valid_i)
                    ghr <= upd_taken_i;
            end
        end else begin : g_histn
            always_ff @(posedge clk_i) begin
                if (!rst_i)
                    ghr <= '0;
                else if (upd_valid_i)
                    ghr <= {ghr[GW-2:0], upd_taken_i};
            end
        end
    endgenerate

    bp_sat_cnt #(.W(STAT_W)) u_br_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (upd_valid_i),
        .cnt_o (br_cnt_o)
    );

    bp_sat_cnt #(.W(STAT_W)) u_miss_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (upd_valid_i & (upd_taken_i ^ upd_pred_i)),
        .cnt_o (miss_cnt_o)
    );

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares. Two instances share the stimulus:
// d0 = plain PC indexing, 32-bit stats; d2 = gshare HIST_W=2, 4-bit stats.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        static_en;
    logic [31:0] lkp_pc;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic        upd_taken;
    logic        upd_pred;

    logic        pred0, pred2;
    logic [3:0]  idx0, idx2;
    logic [31:0] br0, miss0;
    logic [3:0]  br2, miss2;
    logic [0:0]  ghr0;
    logic [1:0]  ghr2;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.IDX_W(4), .HIST_W(0), .STAT_W(32)) d0 (
        .clk_i(clk), .rst_i(rst), .static_i(static_en), .lkp_pc_i(lkp_pc),
        .predict_o(pred0), .lkp_idx_o(idx0), .upd_valid_i(upd_valid),
        .upd_idx_i(upd_idx), .upd_taken_i(upd_taken), .upd_pred_i(upd_pred),
        .br_cnt_o(br0), .miss_cnt_o(miss0), .ghr_o(ghr0)
    );

    branch_predict_ctrl #(.IDX_W(4), .HIST_W(2), .STAT_W(4)) d2 (
        .clk_i(clk), .rst_i(rst), .static_i(static_en), .lkp_pc_i(lkp_pc),
        .predict_o(pred2), .lkp_idx_o(idx2), .upd_valid_i(upd_valid),
        .upd_idx_i(upd_idx), .upd_taken_i(upd_taken), .upd_pred_i(upd_pred),
        .br_cnt_o(br2), .miss_cnt_o(miss2), .ghr_o(ghr2)
    );

    localparam int S_PRED0 = 0, S_IDX0 = 1, S_BR0 = 2, S_MISS0 = 3, S_GHR0 = 4;
    localparam int S_PRED2 = 5, S_IDX2 = 6, S_BR2 = 7, S_MISS2 = 8, S_GHR2 = 9;

    typedef struct {
        int          sel;
        logic [31:0] ev;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            S_PRED0: return 32'(pred0);
            S_IDX0:  return 32'(idx0);
            S_BR0:   return br0;
            S_MISS0: return miss0;
            S_GHR0:  return 32'(ghr0);
            S_PRED2: return 32'(pred2);
            S_IDX2:  return 32'(idx2);
            S_BR2:   return 32'(br2);
            S_MISS2: return 32'(miss2);
            S_GHR2:  return 32'(ghr2);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input int sel, input logic [31:0] ev, input string name);
        exp_t e;
        e.sel  = sel;
        e.ev   = ev;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sbq.pop_front();
            act = probe(e.sel);
            checks++;
            if (act !== e.ev) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.name, act, e.ev);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [3:0] i, input logic t, input logic p);
        upd_valid = v;
        upd_idx   = i;
        upd_taken = t;
        upd_pred  = p;
    endtask

    initial begin
        rst = 1'b0; static_en = 1'b0; lkp_pc = 32'h0;
        upd(1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) cyc();
        rst = 1'b1;

        // Post-reset lookups
        lkp_pc = 32'h00;
        expect_val(S_PRED0, 0, "rst_pred_pc00");
        expect_val(S_PRED2, 0, "rst_pred2_pc00");
        expect_val(S_BR0, 0, "rst_br");
        expect_val(S_MISS0, 0, "rst_miss");
        expect_val(S_GHR0, 0, "rst_ghr0");
        expect_val(S_GHR2, 0, "rst_ghr2");
        cyc();
        lkp_pc = 32'h04;
        expect_val(S_PRED0, 0, "rst_pred_pc04");
        expect_val(S_IDX0, 1, "idx_pc04");
        cyc();
        lkp_pc = 32'h3C;
        expect_val(S_PRED0, 0, "rst_pred_pc3c");
        expect_val(S_IDX0, 15, "idx_pc3c");
        expect_val(S_PRED2, 0, "rst_pred2_pc3c");
        cyc();

        // Two taken updates at idx 4, pred=0; lookup same cycle sees old value
        lkp_pc = 32'h10;
        upd(1'b1, 4'd4, 1'b1, 1'b0);
        expect_val(S_PRED0, 0, "same_cycle_pre_update");
        cyc();
        cyc();
        upd_valid = 1'b0;
        expect_val(S_PRED0, 1, "st_pred");
        expect_val(S_IDX0, 4, "idx_pc10");
        expect_val(S_BR0, 2, "br_after2");
        expect_val(S_MISS0, 2, "miss_after2");
        expect_val(S_GHR2, 3, "ghr_tt");
        expect_val(S_IDX2, 7, "gshare_idx");
        expect_val(S_PRED2, 0, "gshare_pred_idx7");
        expect_val(S_BR2, 2, "br2_after2");
        cyc();

        // Third taken (correctly predicted): saturates at ST
        upd(1'b1, 4'd4, 1'b1, 1'b1);
        cyc();
        upd_valid = 1'b0;
        expect_val(S_PRED0, 1, "st_sat_pred");
        expect_val(S_BR0, 3, "br_after3");
        expect_val(S_MISS0, 2, "miss_no_inc");
        expect_val(S_GHR2, 3, "ghr_ttt");
        cyc();

        // Two not-taken: ST -> WT -> WNT
        upd(1'b1, 4'd4, 1'b0, 1'b1);
        cyc();
        upd_valid = 1'b0;
        expect_val(S_PRED0, 1, "wt_pred");
        expect_val(S_MISS0, 3, "miss_nt1");
        expect_val(S_BR0, 4, "br_nt1");
        expect_val(S_GHR2, 2, "ghr_ttn");
        cyc();
        upd(1'b1, 4'd4, 1'b0, 1'b1);
        cyc();
        upd_valid = 1'b0;
        expect_val(S_PRED0, 0, "wnt_pred");
        expect_val(S_MISS0, 4, "miss_nt2");
        expect_val(S_BR0, 5, "br_nt2");
        expect_val(S_GHR2, 0, "ghr_tnn");
        expect_val(S_IDX2, 4, "gshare_idx_ghr0");
        expect_val(S_PRED2, 0, "gshare_wnt_pred");
        cyc();

        // Simultaneous lookup+update from WNT
        upd(1'b1, 4'd4, 1'b1, 1'b0);
        expect_val(S_PRED0, 0, "bypass_none");
        cyc();
        upd_valid = 1'b0;
        expect_val(S_PRED0, 1, "update_visible");
        expect_val(S_BR0, 6, "br_sim");
        expect_val(S_MISS0, 5, "miss_sim");
        expect_val(S_GHR2, 1, "ghr_nnt");
        expect_val(S_IDX2, 5, "gshare_idx5");
        expect_val(S_PRED2, 0, "gshare_pred_idx5");
        cyc();

        // Static override
        static_en = 1'b1;
        expect_val(S_PRED0, 0, "static_pred0");
        cyc();
        lkp_pc = 32'h14;
        expect_val(S_IDX2, 4, "gshare_idx_pc14");
        expect_val(S_PRED2, 0, "static_pred2");
        cyc();
        static_en = 1'b0;
        expect_val(S_PRED2, 1, "nonstatic_pred2");
        expect_val(S_PRED0, 0, "pred0_idx5");
        cyc();

        // 20 correctly-predicted not-taken: 4-bit br count saturates
        lkp_pc = 32'h00;
        upd(1'b1, 4'd0, 1'b0, 1'b0);
        repeat (20) cyc();
        upd_valid = 1'b0;
        expect_val(S_BR0, 26, "br0_26");
        expect_val(S_BR2, 15, "br2_sat");
        expect_val(S_MISS2, 5, "miss2_5");
        expect_val(S_MISS0, 5, "miss0_5");
        expect_val(S_PRED0, 0, "snt_pred");
        expect_val(S_GHR2, 0, "ghr_zeros");
        cyc();

        // 12 mispredicts: 4-bit miss count saturates
        upd(1'b1, 4'd1, 1'b0, 1'b1);
        repeat (12) cyc();
        upd_valid = 1'b0;
        expect_val(S_MISS2, 15, "miss2_sat");
        expect_val(S_BR2, 15, "br2_still_sat");
        expect_val(S_MISS0, 17, "miss0_17");
        expect_val(S_BR0, 38, "br0_38");
        cyc();

        // Reset with an update presented: reset wins
        lkp_pc = 32'h10;
        rst = 1'b0;
        upd(1'b1, 4'd4, 1'b1, 1'b0);
        cyc();
        rst = 1'b1;
        upd_valid = 1'b0;
        expect_val(S_PRED0, 0, "midrst_pred");
        expect_val(S_BR0, 0, "midrst_br0");
        expect_val(S_MISS0, 0, "midrst_miss0");
        expect_val(S_BR2, 0, "midrst_br2");
        expect_val(S_MISS2, 0, "midrst_miss2");
        expect_val(S_GHR2, 0, "midrst_ghr2");
        expect_val(S_IDX2, 4, "midrst_idx2");
        cyc();
        upd(1'b1, 4'd4, 1'b1, 1'b0);
        cyc();
        upd_valid = 1'b0;
        expect_val(S_PRED0, 1, "postrst_wt");
        expect_val(S_BR0, 1, "postrst_br");
        expect_val(S_MISS0, 1, "postrst_miss");
        expect_val(S_GHR2, 1, "postrst_ghr");
        cyc();
        upd(1'b1, 4'd4, 1'b0, 1'b0);
        cyc();
        upd_valid = 1'b0;
        expect_val(S_PRED0, 0, "postrst_back_wnt");
        cyc();

        cyc();
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
